// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and default widths for the 16-bit multi-cycle CPU.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_pointer_len = 16;
    localparam int c_data_len    = 16;
    localparam int c_timeout     = 15;

    typedef logic [c_data_len-1:0] instr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Purpose  : Instruction-memory read port: single strobe, variable latency.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int POINTER_LEN = c_pointer_len,
    parameter int DATA_LEN    = c_data_len
);

    logic [POINTER_LEN-1:0] mem_addr;
    logic                   mem_rd_en;
    logic [DATA_LEN-1:0]    mem_rdata;
    logic                   mem_rvalid;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        output mem_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_timeout_ctr
//  Purpose  : Saturating wait counter; hit marks the edge it reaches TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      hit
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_max  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  c_last = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted while the edge about to happen brings the count to TIMEOUT.
    assign hit = en && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Fetch stage: reads the word at instruction_ptr into ir and
//             pulses pc_inc_en once the word is safely captured.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int POINTER_LEN = c_pointer_len,
    parameter int DATA_LEN    = c_data_len,
    parameter int TIMEOUT     = c_timeout
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   fetch_req,
    input  wire logic                   flush,
    input  wire logic [POINTER_LEN-1:0] instruction_ptr,
    instr_fetch_unit_if.master          mem,
    output logic [DATA_LEN-1:0]         ir,
    output logic                        ir_valid,
    output logic                        fetch_done,
    output logic                        pc_inc_en,
    output logic                        fetch_busy,
    output logic                        fetch_err
);

    fetch_state_t           r_state;
    logic [POINTER_LEN-1:0] r_mem_addr;
    logic                   r_mem_rd_en;
    logic [DATA_LEN-1:0]    r_ir;
    logic                   r_ir_valid;
    logic                   r_fetch_done;
    logic                   r_pc_inc_en;
    logic                   r_fetch_busy;
    logic                   r_fetch_err;

    logic w_waiting;
    logic w_ctr_clr;
    logic w_ctr_hit;

    // Counter restarts on entry to WAIT (from REQ) and on WAIT -> DRAIN.
    assign w_waiting = (r_state == WAIT) || (r_state == DRAIN);
    assign w_ctr_clr = !w_waiting ||
                       ((r_state == WAIT) && flush && !mem.mem_rvalid);

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (w_ctr_clr),
        .en  (w_waiting),
        .hit (w_ctr_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_ir         <= '0;
            r_ir_valid   <= 1'b0;
            r_fetch_done <= 1'b0;
            r_pc_inc_en  <= 1'b0;
            r_fetch_busy <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_mem_rd_en  <= 1'b0;
            r_fetch_done <= 1'b0;
            r_pc_inc_en  <= 1'b0;
            r_fetch_err  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (fetch_req) begin
                        r_state      <= REQ;
                        r_mem_addr   <= instruction_ptr;
                        r_mem_rd_en  <= 1'b1;
                        r_ir_valid   <= 1'b0;
                        r_fetch_busy <= 1'b1;
                    end else if (flush) begin
                        r_ir_valid   <= 1'b0;
                    end
                end

                REQ: begin
                    r_state <= flush ? DRAIN : WAIT;
                end

                WAIT: begin
                    if (mem.mem_rvalid && flush) begin
                        r_state      <= IDLE;
                        r_fetch_busy <= 1'b0;
                    end else if (mem.mem_rvalid) begin
                        r_state      <= DONE;
                        r_ir         <= mem.mem_rdata;
                        r_ir_valid   <= 1'b1;
                        r_fetch_done <= 1'b1;
                        r_pc_inc_en  <= 1'b1;
                    end else if (flush) begin
                        r_state      <= DRAIN;
                    end else if (w_ctr_hit) begin
                        r_state      <= IDLE;
                        r_fetch_busy <= 1'b0;
                        r_fetch_err  <= 1'b1;
                    end
                end

                DONE: begin
                    r_state      <= IDLE;
                    r_fetch_busy <= 1'b0;
                    if (flush) begin
                        r_ir_valid <= 1'b0;
                    end
                end

                // The outstanding response is swallowed; a silent timeout is not an error here.
                DRAIN: begin
                    if (mem.mem_rvalid || w_ctr_hit) begin
                        r_state      <= IDLE;
                        r_fetch_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_fetch_busy <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_rd_en = r_mem_rd_en;
    assign ir            = r_ir;
    assign ir_valid      = r_ir_valid;
    assign fetch_done    = r_fetch_done;
    assign pc_inc_en     = r_pc_inc_en;
    assign fetch_busy    = r_fetch_busy;
    assign fetch_err     = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Directed scoreboard bench for instr_fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        flush;
    logic [15:0] instruction_ptr;
    logic [15:0] ir;
    logic        ir_valid;
    logic        fetch_done;
    logic        pc_inc_en;
    logic        fetch_busy;
    logic        fetch_err;

    instr_fetch_unit_if #(.POINTER_LEN(16), .DATA_LEN(16)) mif ();

    instr_fetch_unit #(
        .POINTER_LEN (16),
        .DATA_LEN    (16),
        .TIMEOUT     (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .flush           (flush),
        .instruction_ptr (instruction_ptr),
        .mem             (mif.master),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .fetch_done      (fetch_done),
        .pc_inc_en       (pc_inc_en),
        .fetch_busy      (fetch_busy),
        .fetch_err       (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     rd_cnt   = 0;
    int     done_cnt = 0;
    int     err_cnt  = 0;
    int     last_done_edge = 0;
    int     last_err_edge  = 0;
    instr_t exp_q[$];
    instr_t exp_word;
    instr_t last_ir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (mif.mem_rd_en) rd_cnt++;
        if (fetch_err) begin
            err_cnt++;
            last_err_edge = cyc + 1;
        end
        if (fetch_done || pc_inc_en) begin
            check("pc_inc_with_done", 32'(pc_inc_en), 32'(fetch_done));
            if (fetch_done) begin
                done_cnt++;
                last_done_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got ir %h, expected no completion", ir);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("sb_ir", 32'(ir), 32'(exp_word));
                    check("sb_ir_valid", 32'(ir_valid), 32'd1);
                end
            end
        end
    end

    task automatic run_fetch(input logic [15:0] ptr, input instr_t data, input int lat,
                             input bit hold_req, input string tag);
        int rd0;
        int dn0;
        int req_edge;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        instruction_ptr = ptr;
        fetch_req       = 1'b1;
        exp_q.push_back(data);
        @(posedge clk);
        #1 req_edge = cyc;
        @(negedge clk);
        if (!hold_req) fetch_req = 1'b0;
        check({tag, "_addr"}, 32'(mif.mem_addr), 32'(ptr));
        check({tag, "_rd_en"}, 32'(mif.mem_rd_en), 32'd1);
        repeat (lat) @(negedge clk);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = data;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        check({tag, "_ir"}, 32'(ir), 32'(data));
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd1);
        check({tag, "_busy"}, 32'(fetch_busy), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - dn0), 32'd1);
        check({tag, "_rd_count"}, 32'(rd_cnt - rd0), 32'd1);
        // REQ edge + lat cycles to rvalid + one edge into DONE + the edge that takes the pulse.
        check({tag, "_done_latency"}, 32'(last_done_edge - req_edge), 32'(lat + 2));
        last_ir = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int dn0;
        int e0;
        int req_edge;

        rst             = 1'b1;
        fetch_req       = 1'b0;
        flush           = 1'b0;
        instruction_ptr = '0;
        mif.mem_rvalid  = 1'b0;
        mif.mem_rdata   = '0;
        last_ir         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("por_busy", 32'(fetch_busy), 32'd0);
        check("por_ir", 32'(ir), 32'd0);
        check("por_addr", 32'(mif.mem_addr), 32'd0);

        // Reset held for 5 cycles while a fetch sits in WAIT.
        @(negedge clk);
        instruction_ptr = 16'h1111;
        fetch_req       = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        check("wait_busy", 32'(fetch_busy), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_outputs",
              {24'd0, fetch_busy, mif.mem_rd_en, ir_valid, fetch_done, pc_inc_en, fetch_err, 2'b00},
              32'd0);
        check("rst_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        @(negedge clk);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 16'hDEAD;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        @(negedge clk);
        check("late_rvalid_ir", 32'(ir), 32'd0);
        check("late_rvalid_busy", 32'(fetch_busy), 32'd0);

        run_fetch(16'h0040, 16'hA5C3, 1, 1'b0, "basic");
        run_fetch(16'h0041, 16'h3C5A, 7, 1'b1, "lat7");

        // No response: 1 REQ cycle + 15 WAIT cycles, error taken by the following edge.
        e0  = err_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        instruction_ptr = 16'h0100;
        fetch_req       = 1'b1;
        @(posedge clk);
        #1 req_edge = cyc;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int i = 0; i < 40 && err_cnt == e0; i++) @(posedge clk);
        @(negedge clk);
        check("tmo_err_count", 32'(err_cnt - e0), 32'd1);
        check("tmo_latency", 32'(last_err_edge - req_edge), 32'd17);
        check("tmo_ir_valid", 32'(ir_valid), 32'd0);
        check("tmo_busy", 32'(fetch_busy), 32'd0);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 16'hFFFF;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        @(negedge clk);
        check("tmo_ir_kept", 32'(ir), 32'(last_ir));
        check("tmo_no_done", 32'(done_cnt - dn0), 32'd0);

        // Flush in WAIT; the response arrives three cycles later and is drained.
        dn0 = done_cnt;
        @(negedge clk);
        instruction_ptr = 16'h0200;
        fetch_req       = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_busy", 32'(fetch_busy), 32'd1);
        repeat (2) @(negedge clk);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 16'h1234;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        @(negedge clk);
        check("flush_busy", 32'(fetch_busy), 32'd0);
        check("flush_ir_kept", 32'(ir), 32'(last_ir));
        check("flush_ir_valid", 32'(ir_valid), 32'd0);
        check("flush_no_done", 32'(done_cnt - dn0), 32'd0);
        run_fetch(16'h0202, 16'h0BEE, 2, 1'b0, "post_flush");

        // flush and rvalid in the same WAIT cycle.
        dn0 = done_cnt;
        @(negedge clk);
        instruction_ptr = 16'h0300;
        fetch_req       = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        flush          = 1'b1;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 16'h7777;
        @(negedge clk);
        flush          = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        check("simul_busy", 32'(fetch_busy), 32'd0);
        check("simul_ir_kept", 32'(ir), 32'(last_ir));
        check("simul_ir_valid", 32'(ir_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("simul_no_done", 32'(done_cnt - dn0), 32'd0);

        check("total_done", 32'(done_cnt), 32'd3);
        check("total_err", 32'(err_cnt), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
